// File: rtl/ram_arbiter_2p_pkg.sv
// rtl/ram_arbiter_2p_pkg.sv - shared types for the two-port memory arbiter
package ram_arbiter_2p_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GNT_A = 2'd2,
    ST_GNT_B = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/ram_arbiter_2p_rr_arb2.sv
// rtl/ram_arbiter_2p_rr_arb2.sv - two-way round-robin pick from a request pair
module ram_arbiter_2p_rr_arb2
  import ram_arbiter_2p_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last_gnt,
  output logic  pick_valid,
  output port_t pick
);

  // On a tie the side that was not served last wins.
  always_comb begin
    pick_valid = req_a | req_b;
    pick       = PORT_A;
    if (req_a && req_b) begin
      pick = other_port(last_gnt);
    end else if (req_b) begin
      pick = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// rtl/ram_arbiter_2p.sv - single-port memory shared round-robin between two requesters
module ram_arbiter_2p
  import ram_arbiter_2p_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  arb_state_t        state;
  arb_state_t        next_state;
  logic [ADDR_W-1:0] init_cnt;
  port_t             last_gnt;
  logic              pick_valid;
  port_t             pick;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              a_rd;
  logic              b_rd;
  logic [DATA_W-1:0] mem [DEPTH];

  ram_arbiter_2p_rr_arb2 u_rr (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_gnt   (last_gnt),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // A granted side still holds its request this cycle, so only the other side can follow.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: begin
        if (init_cnt == {ADDR_W{1'b1}}) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (pick_valid) next_state = (pick == PORT_A) ? ST_GNT_A : ST_GNT_B;
      end
      ST_GNT_A: next_state = b_req ? ST_GNT_B : ST_IDLE;
      ST_GNT_B: next_state = a_req ? ST_GNT_A : ST_IDLE;
      default:  next_state = ST_INIT;
    endcase
  end

  // Grants and memory writes are masked while rst is high so a reset aborts the access.
  always_comb begin
    init_done = (state != ST_INIT) && !rst;
    a_gnt     = (state == ST_GNT_A) && !rst;
    b_gnt     = (state == ST_GNT_B) && !rst;
    a_rd      = a_gnt && !a_we;
    b_rd      = b_gnt && !b_we;
    mem_we    = 1'b0;
    mem_waddr = init_cnt;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        ST_INIT: mem_we = 1'b1;
        ST_GNT_A: begin
          mem_we    = a_we;
          mem_waddr = a_addr;
          mem_wdata = a_wdata;
        end
        ST_GNT_B: begin
          mem_we    = b_we;
          mem_waddr = b_addr;
          mem_wdata = b_wdata;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      last_gnt <= PORT_B;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (a_gnt) begin
        last_gnt <= PORT_A;
      end else if (b_gnt) begin
        last_gnt <= PORT_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= mem[a_addr];
      if (b_rd) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb/tb_ram_arbiter_2p.sv - self-checking bench for ram_arbiter_2p
module tb_ram_arbiter_2p;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_done;
  logic              a_req = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              a_gnt, a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_gnt, b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word array, per-side expected read results, init countdown.
  logic [DATA_W-1:0] mm [DEPTH];
  logic [DATA_W-1:0] exp_rd_a = '0, exp_rd_b = '0;
  bit                exp_rv_a = 0, exp_rv_b = 0;
  bit                prev_a = 0, prev_b = 0;
  int                init_left = DEPTH;
  int                wait_a = 0, wait_b = 0;
  bit                mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("gnt_mutex", a_gnt & b_gnt, 0);
      check_eq("a_rvalid", a_rvalid, exp_rv_a);
      check_eq("b_rvalid", b_rvalid, exp_rv_b);
      check_eq("a_rdata", a_rdata, exp_rd_a);
      check_eq("b_rdata", b_rdata, exp_rd_b);
      check_eq("gnt_no_init", (a_gnt | b_gnt) & !init_done, 0);
      if (rst) begin
        check_eq("gnt_in_rst", a_gnt | b_gnt, 0);
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        exp_rd_a = '0; exp_rd_b = '0;
        exp_rv_a = 0;  exp_rv_b = 0;
        prev_a = 0; prev_b = 0; wait_a = 0; wait_b = 0;
        init_left = DEPTH;
      end else begin
        check_eq("init_done", init_done, init_left == 0);
        exp_rv_a = 0;
        exp_rv_b = 0;
        if (a_gnt) begin
          check_eq("a_gnt_req", a_req, 1);
          check_eq("a_b2b_same", prev_a, 0);
          check_eq("a_wait_bound", wait_a <= 2, 1);
          wait_a = 0;
          if (a_we) mm[a_addr] = a_wdata;
          else begin exp_rd_a = mm[a_addr]; exp_rv_a = 1; end
        end else if (a_req && init_left == 0) wait_a++;
        else if (!a_req) wait_a = 0;
        if (b_gnt) begin
          check_eq("b_gnt_req", b_req, 1);
          check_eq("b_b2b_same", prev_b, 0);
          check_eq("b_wait_bound", wait_b <= 2, 1);
          wait_b = 0;
          if (b_we) mm[b_addr] = b_wdata;
          else begin exp_rd_b = mm[b_addr]; exp_rv_b = 1; end
        end else if (b_req && init_left == 0) wait_b++;
        else if (!b_req) wait_b = 0;
        prev_a = a_gnt;
        prev_b = b_gnt;
        if (init_left > 0) init_left--;
      end
    end
  end

  task automatic set_req(input bit side, input bit req, input bit we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (side) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; end
  endtask

  task automatic wait_gnt(input bit side, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(side ? b_gnt : a_gnt) && n < 40);
    check_eq(side ? "b_gnt_seen" : "a_gnt_seen", side ? b_gnt : a_gnt, 1);
  endtask

  task automatic do_access(input bit side, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, output int n);
    set_req(side, 1, we, addr, wdata);
    wait_gnt(side, n);
    @(posedge clk); #1;
    set_req(side, 0, 0, '0, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    // Reset with A already requesting a read of address 5
    @(posedge clk); #1;
    mon_en = 1;
    set_req(0, 1, 0, 3'd5, '0);
    @(posedge clk); #1;
    rst = 0;
    wait_gnt(0, n);
    check_eq("t1_gnt_cycle", n, 10);
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    check_eq("t1_rvalid", a_rvalid, 1);
    check_eq("t1_rdata", a_rdata, 8'h00);

    // Single write then read on A
    @(posedge clk); #1;
    do_access(0, 1, 3'd3, 8'hA5, n);
    do_access(0, 0, 3'd3, '0, n);
    check_eq("t2_rd_latency", n, 2);
    @(negedge clk);
    check_eq("t2_rvalid", a_rvalid, 1);
    check_eq("t2_rdata", a_rdata, 8'hA5);
    check_eq("t2_gnt_pulse", a_gnt, 0);

    // Coherency: A writes 7, B reads 7 on the following grant
    @(posedge clk); #1;
    set_req(0, 1, 1, 3'd7, 8'h3C);
    @(posedge clk); #1;
    set_req(1, 1, 0, 3'd7, '0);
    @(negedge clk);
    check_eq("t4_a_gnt", a_gnt, 1);
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    check_eq("t4_b_gnt", b_gnt, 1);
    @(posedge clk); #1;
    set_req(1, 0, 0, '0, '0);
    @(negedge clk);
    check_eq("t4_b_rvalid", b_rvalid, 1);
    check_eq("t4_b_rdata", b_rdata, 8'h3C);

    // Contention through reset: both request continuously, grants alternate from A
    @(posedge clk); #1;
    rst = 1;
    set_req(0, 1, 1, 3'd6, 8'h5A);
    set_req(1, 1, 0, 3'd6, '0);
    @(posedge clk); #1;
    rst = 0;
    wait_gnt(0, n);
    check_eq("t3_first_gnt_cycle", n, 10);
    check_eq("t3_first_not_b", b_gnt, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq("t3_alt_a", a_gnt, (k % 2) == 0);
      check_eq("t3_alt_b", b_gnt, (k % 2) == 1);
      if (k == 4) begin
        @(posedge clk); #1;
        set_req(0, 0, 0, '0, '0);
      end
    end
    @(posedge clk); #1;
    set_req(1, 0, 0, '0, '0);

    // Reset during a B write of 8'hFF to address 2
    @(posedge clk); #1;
    set_req(1, 1, 1, 3'd2, 8'hFF);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check_eq("t5_gnt_masked", b_gnt, 0);
    @(posedge clk); #1;
    rst = 0;
    set_req(1, 0, 0, '0, '0);
    @(negedge clk);
    check_eq("t5_b_rdata_clr", b_rdata, 8'h00);
    check_eq("t5_init_low", init_done, 0);
    @(posedge clk); #1;
    do_access(0, 0, 3'd2, '0, n);
    @(negedge clk);
    check_eq("t5_rvalid", a_rvalid, 1);
    check_eq("t5_rdata", a_rdata, 8'h00);

    // Randomized traffic from both sides; the monitor model checks every cycle
    @(posedge clk); #1;
    fork
      begin
        int na;
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_access(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, DEPTH - 1)),
                    8'($urandom), na);
        end
      end
      begin
        int nb;
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_access(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, DEPTH - 1)),
                    8'($urandom), nb);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
